// File: rtl/demux_lanes_if.sv
// rtl/demux_lanes_if.sv - stream input and per-lane output bundle for demux_lanes
// The slave modport is the demultiplexer's view; master is the driver/consumer side.
interface demux_lanes_if #(
  parameter int DATA_W = 8
);
  logic              valid_in;
  logic [DATA_W-1:0] data_in;
  logic              ready_0;
  logic              ready_1;
  logic              valid_out_0;
  logic [DATA_W-1:0] data_out_0;
  logic              valid_out_1;
  logic [DATA_W-1:0] data_out_1;
  logic              full_0;
  logic              full_1;
  logic              overflow_0;
  logic              overflow_1;
  logic              lane_sel;

  modport master (
    output valid_in, data_in, ready_0, ready_1,
    input  valid_out_0, data_out_0, valid_out_1, data_out_1,
    input  full_0, full_1, overflow_0, overflow_1, lane_sel
  );

  modport slave (
    input  valid_in, data_in, ready_0, ready_1,
    output valid_out_0, data_out_0, valid_out_1, data_out_1,
    output full_0, full_1, overflow_0, overflow_1, lane_sel
  );
endinterface

// File: rtl/demux_lanes.sv
// rtl/demux_lanes.sv - 1:2 lane demux with per-lane show-ahead FIFOs
// Optional DEMUX_IDLE_RESYNC_EN: after IDLE_LIMIT idle cycles the next word restarts at lane 0.
module demux_lanes #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int IDLE_LIMIT = 4
) (
  input  logic          clk_2f,
  input  logic          reset_L,
  demux_lanes_if.slave  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = FIFO_DEPTH[PTR_W:0];

  localparam logic [0:0] WAIT_L0 = 1'b0;
  localparam logic [0:0] WAIT_L1 = 1'b1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || IDLE_LIMIT < 1) begin : g_param_check
    $error("demux_lanes: FIFO_DEPTH must be a power of 2 >= 2 and IDLE_LIMIT >= 1");
  end

  logic [0:0]                   lane_state;
  logic                         resync;
  logic [1:0]                   push;
  logic [1:0]                   ready;
  logic [1:0]                   valid_w;
  logic [1:0]                   full_w;
  logic [1:0]                   ovf_w;
  logic [1:0][DATA_W-1:0]       head_w;

  assign ready   = {bus.ready_1, bus.ready_0};
  assign push[0] = bus.valid_in && (lane_state == WAIT_L0);
  assign push[1] = bus.valid_in && (lane_state == WAIT_L1);

`ifdef DEMUX_IDLE_RESYNC_EN
  localparam int IDLE_W = $clog2(IDLE_LIMIT) + 1;
  localparam logic [IDLE_W-1:0] IDLE_C = IDLE_LIMIT[IDLE_W-1:0];

  logic [IDLE_W-1:0] idle_cnt;
  logic [IDLE_W-1:0] idle_next;

  // Saturates at the limit so a long gap keeps the FSM parked on lane 0.
  assign idle_next = bus.valid_in ? '0 :
                     (idle_cnt == IDLE_C) ? IDLE_C : idle_cnt + 1'b1;
  assign resync    = (idle_next == IDLE_C);

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_next;
    end
  end
`else
  assign resync = 1'b0;
`endif

  // Dropped words still advance the FSM so later words keep their lane.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      lane_state <= WAIT_L0;
    end else if (resync) begin
      lane_state <= WAIT_L0;
    end else if (bus.valid_in) begin
      lane_state <= (lane_state == WAIT_L0) ? WAIT_L1 : WAIT_L0;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              empty;
    logic              full;
    logic              pop;
    logic              accept;
    logic              ovf;

    assign empty  = (count == '0);
    assign full   = (count == DEPTH_C);
    assign pop    = !empty && ready[g];
    // A same-cycle pop frees the slot, so a full lane still takes the word.
    assign accept = push[g] && (!full || pop);

    always_ff @(posedge clk_2f or negedge reset_L) begin
      if (!reset_L) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
          mem[i] <= '0;
        end
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        ovf    <= 1'b0;
      end else begin
        if (accept) begin
          mem[wr_ptr] <= bus.data_in;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (accept && !pop) begin
          count <= count + 1'b1;
        end else if (pop && !accept) begin
          count <= count - 1'b1;
        end
        if (push[g] && !accept) begin
          ovf <= 1'b1;
        end
      end
    end

    assign valid_w[g] = !empty;
    assign full_w[g]  = full;
    assign ovf_w[g]   = ovf;
    assign head_w[g]  = empty ? '0 : mem[rd_ptr];
  end

  assign bus.valid_out_0 = valid_w[0];
  assign bus.valid_out_1 = valid_w[1];
  assign bus.data_out_0  = head_w[0];
  assign bus.data_out_1  = head_w[1];
  assign bus.full_0      = full_w[0];
  assign bus.full_1      = full_w[1];
  assign bus.overflow_0  = ovf_w[0];
  assign bus.overflow_1  = ovf_w[1];
  assign bus.lane_sel    = (lane_state == WAIT_L1);
endmodule

// File: doc/demux_lanes.md
Name: demux_lanes

Overview:
- Inverse of the 2:1 lane mux in the PHY: takes the single interleaved byte stream at clk_2f and splits it back into lane 0 and lane 1.
- Consecutive valid words are distributed alternately to the two lanes, starting at lane 0.
- Each lane has a small show-ahead FIFO with a ready/valid output handshake, so the lane consumers can stall independently.
- Sits on the receive side of the PHY, between the stream deserialiser and the per-lane consumers.

Parameters:
- DATA_W, 8, width of stream and lane data.
- FIFO_DEPTH, 4, entries per lane FIFO; power of 2, minimum 2.
- IDLE_LIMIT, 4, idle cycles before lane resync (used only with the optional feature).

Ports:
- clk_2f  input  1  block clock; all state updates on the rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- valid_in  input  1  data_in carries a word this cycle.
- data_in  input  DATA_W  interleaved stream word.
- ready_0  input  1  lane 0 consumer accepts the head word.
- ready_1  input  1  lane 1 consumer accepts the head word.
- valid_out_0  output  1  lane 0 FIFO is non-empty.
- data_out_0  output  DATA_W  lane 0 head word.
- valid_out_1  output  1  lane 1 FIFO is non-empty.
- data_out_1  output  DATA_W  lane 1 head word.
- full_0, full_1  output  1 each  lane FIFO holds FIFO_DEPTH entries.
- overflow_0, overflow_1  output  1 each  sticky: a word destined for the lane was dropped.
- lane_sel  output  1  current FSM state; 0 = next valid word goes to lane 0.

Behaviour:
- Reset: reset_L low asynchronously clears every register, independent of clk_2f.
  - FSM to WAIT_L0; FIFO pointers and counts to 0.
  - All outputs 0: valid_out_x, full_x, overflow_x, lane_sel, data_out_x.
  - Reset mid-stream discards all buffered words; the first valid word after release goes to lane 0.
- FSM, two states:
  - WAIT_L0 + valid_in: push data_in to lane 0, next state WAIT_L1.
  - WAIT_L1 + valid_in: push data_in to lane 1, next state WAIT_L0.
  - valid_in low: hold state. Gaps never change the alternation.
- lane_sel is 1 exactly in WAIT_L1.
- Push latency: a word pushed into an empty lane at edge N makes valid_out_x = 1 with data_out_x = that word immediately after edge N (1 cycle).
- Lane FIFO, show-ahead:
  - valid_out_x = !empty; data_out_x = head entry.
  - Pop occurs when valid_out_x && ready_x at the edge.
  - data_out_x is 0 while empty.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is log2(FIFO_DEPTH)+1 bits.
  - full_x = (count == FIFO_DEPTH).
- Push and pop in the same cycle:
  - Both are performed and count is unchanged.
  - This includes the full case: the pop frees the slot and the push is accepted, with no overflow.
- Push to a full lane without a same-cycle pop:
  - The word is dropped and overflow_x is set.
  - The FSM still toggles, preserving alternation for later words.
  - FIFO contents are unchanged.
- overflow_x clears only on reset.
- ready_x while the lane is empty is ignored.
- The two lanes are fully independent apart from the shared FSM.

Optional Feature:
- Macro: DEMUX_IDLE_RESYNC_EN.
- When defined:
  - An idle counter (log2(IDLE_LIMIT)+1 bits) increments on each cycle with valid_in low and clears on any valid_in.
  - When it reaches IDLE_LIMIT, the FSM is forced to WAIT_L0 on that edge and the counter saturates until the next valid word.
  - This realigns the lanes after a burst gap, matching a transmitter that restarts interleaving at lane 0.
- When not defined: no counter is present, and the FSM holds its state across any number of idle cycles.

Test Plan:
- Alternation: ready_0 = ready_1 = 1; send 0xA0, 0xA1, 0xA2, 0xA3 back-to-back.
  - Lane 0 shows 0xA0 then 0xA2; lane 1 shows 0xA1 then 0xA3.
  - Each word appears one cycle after its push; lane_sel toggles 0, 1, 0, 1.
- Gaps: send 0x11, idle 2 cycles, 0x22, idle 1 cycle, 0x33 (resync macro off).
  - 0x11 and 0x33 go to lane 0; 0x22 goes to lane 1.
- Backpressure and overflow: ready_0 = 0, ready_1 = 1; send 0x00 to 0x09.
  - Lane 0 holds 0x00, 0x02, 0x04, 0x06 and full_0 = 1.
  - 0x08 is dropped and overflow_0 = 1; lane 1 drains 0x01 to 0x09; overflow_1 = 0.
- Full with simultaneous pop: lane 0 full, assert ready_0 in the same cycle lane 0 receives 0x55.
  - Head 0x00 pops, 0x55 is accepted as the tail, full_0 stays 1, overflow_0 stays 0.
- Reset mid-operation: with both lanes holding 3 words, pulse reset_L low between clock edges.
  - Outputs clear immediately, without waiting for a clock edge.
  - After release, 0x77 goes to lane 0.
- Resync (macro on, IDLE_LIMIT = 4): send 0x01 (lane 0), idle 4 cycles, send 0x02.
  - 0x02 goes to lane 0 and lane_sel returns to 0 during the idle period.
  - With an idle of only 3 cycles, 0x02 goes to lane 1.
